store_buffer: RTL and testbench

- Posted-write buffer between the Memory stage and Dmem.
- Accepts stores in one cycle and retires them to Dmem in FIFO order in the background.
- Lets non-overlapping loads bypass older buffered stores, and forwards fully covered loads directly from the buffer.
- Removes store latency from the Memory-stage stall path (stallControl).

---
 rtl/store_buffer_if.sv | 38 +++
 rtl/store_buffer.sv | 192 +++++++++++++++++++
 tb/tb_store_buffer.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// Memory-stage and Dmem signal bundle for store_buffer; the slave modport is the buffer's view.
interface store_buffer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    storeValid;
  logic                    loadValid;
  logic [31:0]             address;
  logic [DATA_WIDTH-1:0]   storeData;
  logic [DATA_WIDTH/8-1:0] byteEnable;
  logic                    drain;
  logic                    storeComplete;
  logic [DATA_WIDTH-1:0]   loadData;
  logic                    loadDataValid;
  logic                    empty;
  logic                    full;
  logic [31:0]             dmemAddress;
  logic [DATA_WIDTH-1:0]   dmemStoreData;
  logic [DATA_WIDTH/8-1:0] dmemByteEnable;
  logic                    dmemStoreValid;
  logic                    dmemLoadValid;
  logic [DATA_WIDTH-1:0]   dmemLoadData;
  logic                    dmemLoadDataValid;
  logic                    dmemStoreComplete;

  modport slave (
    input  storeValid, loadValid, address, storeData, byteEnable, drain,
           dmemLoadData, dmemLoadDataValid, dmemStoreComplete,
    output storeComplete, loadData, loadDataValid, empty, full,
           dmemAddress, dmemStoreData, dmemByteEnable, dmemStoreValid, dmemLoadValid
  );

  modport master (
    output storeValid, loadValid, address, storeData, byteEnable, drain,
           dmemLoadData, dmemLoadDataValid, dmemStoreComplete,
    input  storeComplete, loadData, loadDataValid, empty, full,
           dmemAddress, dmemStoreData, dmemByteEnable, dmemStoreValid, dmemLoadValid
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-write store buffer between the Memory stage and Dmem, retiring stores in FIFO order.
// Define STORE_BUFFER_FORWARD_EN to forward loads whose lanes are all covered by buffered stores.
module store_buffer #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32
) (
  input logic           clock,
  input logic           reset,
  store_buffer_if.slave bus
);
  localparam int NB  = DATA_WIDTH / 8;
  localparam int LSB = $clog2(NB);
  localparam int AW  = 32 - LSB;
  localparam int PW  = $clog2(DEPTH);

  typedef enum logic [1:0] {L_IDLE, L_CHECK, L_WAIT, L_RESP} lstate_t;
  typedef enum logic {D_IDLE, D_ISSUE} dstate_t;

  lstate_t r_lstate, w_lnext;
  dstate_t r_dstate, w_dnext;

  logic [AW-1:0]         r_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [NB-1:0]         r_be   [DEPTH];
  logic [DEPTH-1:0]      r_valid;
  logic [DEPTH-1:0]      r_snap;
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [PW:0]           r_count;
  logic                  r_full;
  logic                  r_storeComplete;
  logic [AW-1:0]         r_ldAddr;
  logic [DATA_WIDTH-1:0] r_loadData;
  logic [31:0]           r_dmemAddr;
  logic [DATA_WIDTH-1:0] r_dmemData;
  logic [NB-1:0]         r_dmemBe;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_empty;
  logic                  w_ldArrive;
  logic                  w_ldIssue;
  logic                  w_stIssue;
  logic                  w_fwd;
  logic [NB-1:0]         w_hit;
  logic [PW-1:0]         w_idx;
  logic [PW:0]           w_countNext;
  logic [DEPTH-1:0]      w_pushMask;
  logic [DEPTH-1:0]      w_popMask;
`ifdef STORE_BUFFER_FORWARD_EN
  logic [DATA_WIDTH-1:0] w_fwdData;
`endif

  assign w_push     = bus.storeValid && !r_full && !bus.drain && !r_storeComplete;
  assign w_pop      = (r_dstate == D_ISSUE) && bus.dmemStoreComplete;
  assign w_empty    = (r_count == '0) && (r_dstate == D_IDLE);
  assign w_ldArrive = bus.loadValid && !bus.storeValid;

  // Walk entries oldest to youngest so the youngest matching store owns each lane.
  // Only entries present when the load was accepted (r_snap) are considered.
  always_comb begin
    w_hit = '0;
    w_idx = r_head;
`ifdef STORE_BUFFER_FORWARD_EN
    w_fwdData = '0;
`endif
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PW'(i);
      if (r_valid[w_idx] && r_snap[w_idx] && (r_addr[w_idx] == r_ldAddr)) begin
        for (int unsigned b = 0; b < NB; b++) begin
          if (r_be[w_idx][b]) begin
            w_hit[b] = 1'b1;
`ifdef STORE_BUFFER_FORWARD_EN
            w_fwdData[b*8 +: 8] = r_data[w_idx][b*8 +: 8];
`endif
          end
        end
      end
    end
  end

`ifdef STORE_BUFFER_FORWARD_EN
  assign w_fwd = &w_hit;
`else
  assign w_fwd = 1'b0;
`endif

  // A load ready to issue beats a drain, and a newly arriving load also holds off a drain start.
  assign w_ldIssue = (r_lstate == L_CHECK) && (r_dstate == D_IDLE) && !w_fwd &&
                     ((w_hit == '0) || w_empty);
  assign w_stIssue = (r_dstate == D_IDLE) && (r_count != '0) && (r_lstate != L_WAIT) &&
                     !w_ldIssue && !((r_lstate == L_IDLE) && w_ldArrive);

  always_comb begin
    w_countNext = r_count;
    if (w_push && !w_pop)      w_countNext = r_count + 1'b1;
    else if (!w_push && w_pop) w_countNext = r_count - 1'b1;
    w_pushMask = '0;
    w_popMask  = '0;
    if (w_push) w_pushMask[r_tail] = 1'b1;
    if (w_pop)  w_popMask[r_head]  = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_lstate <= L_IDLE;
      r_dstate <= D_IDLE;
    end else begin
      r_lstate <= w_lnext;
      r_dstate <= w_dnext;
    end
  end

  always_comb begin
    w_lnext = r_lstate;
    case (r_lstate)
      L_IDLE:  if (w_ldArrive) w_lnext = L_CHECK;
      L_CHECK: begin
        if (w_fwd)          w_lnext = L_RESP;
        else if (w_ldIssue) w_lnext = L_WAIT;
      end
      L_WAIT:  if (bus.dmemLoadDataValid) w_lnext = L_RESP;
      L_RESP:  w_lnext = L_IDLE;
      default: w_lnext = L_IDLE;
    endcase
    w_dnext = r_dstate;
    case (r_dstate)
      D_IDLE:  if (w_stIssue) w_dnext = D_ISSUE;
      D_ISSUE: if (bus.dmemStoreComplete) w_dnext = D_IDLE;
      default: w_dnext = D_IDLE;
    endcase
  end

  always_comb begin
    bus.storeComplete  = r_storeComplete;
    bus.loadData       = r_loadData;
    bus.loadDataValid  = (r_lstate == L_RESP);
    bus.empty          = w_empty;
    bus.full           = r_full;
    bus.dmemAddress    = r_dmemAddr;
    bus.dmemStoreData  = r_dmemData;
    bus.dmemByteEnable = r_dmemBe;
    bus.dmemStoreValid = (r_dstate == D_ISSUE);
    bus.dmemLoadValid  = (r_lstate == L_WAIT);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_head          <= '0;
      r_tail          <= '0;
      r_count         <= '0;
      r_full          <= 1'b0;
      r_valid         <= '0;
      r_snap          <= '0;
      r_storeComplete <= 1'b0;
      r_ldAddr        <= '0;
      r_loadData      <= '0;
      r_dmemAddr      <= '0;
      r_dmemData      <= '0;
      r_dmemBe        <= '0;
    end else begin
      r_storeComplete <= w_push;
      r_count         <= w_countNext;
      r_full          <= (w_countNext == (PW+1)'(DEPTH));
      r_valid         <= (r_valid | w_pushMask) & ~w_popMask;
      r_snap          <= (((r_lstate == L_IDLE) && w_ldArrive) ? r_valid : r_snap) & ~w_popMask;
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      if ((r_lstate == L_IDLE) && w_ldArrive) r_ldAddr <= bus.address[31:LSB];
      if (w_ldIssue) begin
        r_dmemAddr <= {r_ldAddr, {LSB{1'b0}}};
        r_dmemBe   <= '0;
      end else if (w_stIssue) begin
        r_dmemAddr <= {r_addr[r_head], {LSB{1'b0}}};
        r_dmemData <= r_data[r_head];
        r_dmemBe   <= r_be[r_head];
      end
      if ((r_lstate == L_WAIT) && bus.dmemLoadDataValid) r_loadData <= bus.dmemLoadData;
`ifdef STORE_BUFFER_FORWARD_EN
      else if ((r_lstate == L_CHECK) && w_fwd) r_loadData <= w_fwdData;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_addr[r_tail] <= bus.address[31:LSB];
      r_data[r_tail] <= bus.storeData;
      r_be[r_tail]   <= bus.byteEnable;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random stores/loads against a
// flat byte-merging memory model.
module tb_store_buffer;
  logic clock = 1'b0;
  logic reset;
  store_buffer_if #(.DATA_WIDTH(32)) bus ();

  store_buffer #(.DEPTH(4), .DATA_WIDTH(32)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  int unsigned stall_until = 0;
  logic [31:0] mem  [int unsigned];
  logic [31:0] refm [int unsigned];
  logic [31:0] retired [$];
  logic        busy = 1'b0;
  int unsigned lat  = 0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    case (a & ~32'h3)
      32'h3000: return 32'h5566_7788;
      32'h5000: return 32'hCAFE_F00D;
      default:  return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old & ~m) | (d & m);
  endfunction

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a >> 2)) return mem[a >> 2];
    return init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (refm.exists(a >> 2)) return refm[a >> 2];
    return init_word(a);
  endfunction

  // Dmem responder: random latency, completion withheld while cyc < stall_until.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    bus.dmemStoreComplete <= 1'b0;
    bus.dmemLoadDataValid <= 1'b0;
    if (!reset) begin
      busy <= 1'b0;
    end else if (busy) begin
      if (lat != 0) lat <= lat - 1;
      else if (cyc >= stall_until) begin
        busy <= 1'b0;
        if (bus.dmemStoreValid) begin
          mem[bus.dmemAddress >> 2] = merge(rd(bus.dmemAddress), bus.dmemStoreData, bus.dmemByteEnable);
          retired.push_back(bus.dmemAddress);
          bus.dmemStoreComplete <= 1'b1;
        end else if (bus.dmemLoadValid) begin
          bus.dmemLoadData      <= rd(bus.dmemAddress);
          bus.dmemLoadDataValid <= 1'b1;
        end
      end
    end else if ((bus.dmemStoreValid || bus.dmemLoadValid) &&
                 !bus.dmemStoreComplete && !bus.dmemLoadDataValid) begin
      busy <= 1'b1;
      lat  <= $urandom_range(0, 2);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_storeComplete"}, 32'(bus.storeComplete), 32'd0);
    check({pfx, "_loadDataValid"}, 32'(bus.loadDataValid), 32'd0);
    check({pfx, "_loadData"}, bus.loadData, 32'd0);
    check({pfx, "_empty"}, 32'(bus.empty), 32'd1);
    check({pfx, "_full"}, 32'(bus.full), 32'd0);
    check({pfx, "_dmemAddress"}, bus.dmemAddress, 32'd0);
    check({pfx, "_dmemStoreData"}, bus.dmemStoreData, 32'd0);
    check({pfx, "_dmemByteEnable"}, 32'(bus.dmemByteEnable), 32'd0);
    check({pfx, "_dmemStoreValid"}, 32'(bus.dmemStoreValid), 32'd0);
    check({pfx, "_dmemLoadValid"}, 32'(bus.dmemLoadValid), 32'd0);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                          output int unsigned slat);
    bit got;
    got  = 1'b0;
    slat = 0;
    bus.storeValid = 1'b1;
    bus.loadValid  = 1'b0;
    bus.address    = a;
    bus.storeData  = d;
    bus.byteEnable = be;
    for (int unsigned t = 1; t <= 100 && !got; t++) begin
      tick();
      if (bus.storeComplete) begin
        got  = 1'b1;
        slat = t;
      end
    end
    bus.storeValid = 1'b0;
    check("store_ack", 32'(got), 32'd1);
    if (got) refm[a >> 2] = merge(ref_rd(a), d, be);
  endtask

  task automatic do_load(input logic [31:0] a, output logic [31:0] d, output int unsigned llat,
                         output bit saw, output int unsigned rc, output int unsigned gap);
    bit got;
    int unsigned dv_t;
    got = 1'b0; dv_t = 0; d = '0; llat = 0; saw = 1'b0; rc = 0; gap = 0;
    bus.storeValid = 1'b0;
    bus.loadValid  = 1'b1;
    bus.address    = a;
    for (int unsigned t = 1; t <= 300 && !got; t++) begin
      tick();
      if (bus.dmemLoadValid && !saw) begin
        saw = 1'b1;
        rc  = retired.size();
      end
      if (bus.dmemLoadDataValid) dv_t = t;
      if (bus.loadDataValid) begin
        got  = 1'b1;
        llat = t;
        d    = bus.loadData;
        gap  = t - dv_t;
      end
    end
    bus.loadValid = 1'b0;
    check("load_resp", 32'(got), 32'd1);
  endtask

  task automatic wait_empty();
    bit e;
    e = 1'b0;
    for (int unsigned t = 0; t < 300 && !e; t++) begin
      tick();
      e = bus.empty;
    end
    check("wait_empty", 32'(e), 32'd1);
  endtask

  initial begin
    int unsigned slat, llat, rc, gap, base;
    bit saw;
    logic [31:0] d, a, sd;
    logic [3:0]  be;

    reset = 1'b0;
    bus.storeValid = 1'b0;
    bus.loadValid  = 1'b0;
    bus.address    = '0;
    bus.storeData  = '0;
    bus.byteEnable = '0;
    bus.drain      = 1'b0;
    repeat (3) tick();
    check_idle_outputs("rst");
    reset = 1'b1;
    tick();

    // 1: single store, one-cycle ack, retires to Dmem
    do_store(32'h1000, 32'hDEAD_BEEF, 4'hF, slat);
    check("t1_ack_latency", slat, 32'd1);
    wait_empty();
    check("t1_dmem_word", rd(32'h1000), 32'hDEAD_BEEF);

    // drain input blocks new stores
    bus.drain = 1'b1;
    bus.storeValid = 1'b1;
    bus.address = 32'h7000;
    bus.storeData = 32'h1234_5678;
    bus.byteEnable = 4'hF;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("drain_blocks_push", 32'(bus.storeComplete), 32'd0);
    end
    bus.drain = 1'b0;
    do_store(32'h7000, 32'h1234_5678, 4'hF, slat);
    wait_empty();

    // 2: fill under a stalled Dmem, 5th store waits, FIFO retire order
    base = retired.size();
    stall_until = 32'hFFFF_FFFF;
    for (int unsigned i = 0; i < 4; i++) do_store(32'(i * 4), 32'hA0 + i, 4'hF, slat);
    tick();
    check("t2_full", 32'(bus.full), 32'd1);
    bus.storeValid = 1'b1;
    bus.address = 32'h10;
    bus.storeData = 32'hA4;
    bus.byteEnable = 4'hF;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t2_no_push_full", 32'(bus.storeComplete), 32'd0);
    end
    stall_until = 0;
    do_store(32'h10, 32'hA4, 4'hF, slat);
    wait_empty();
    check("t2_retire_count", retired.size() - base, 32'd5);
    for (int unsigned i = 0; i < 5; i++)
      if (base + i < retired.size()) check("t2_retire_order", retired[base + i], 32'(i * 4));

    // 3: fully covered load
    stall_until = cyc + 12;
    do_store(32'h2000, 32'h1122_3344, 4'hF, slat);
    do_load(32'h2000, d, llat, saw, rc, gap);
    check("t3_data", d, 32'h1122_3344);
`ifdef STORE_BUFFER_FORWARD_EN
    check("t3_fwd_latency", llat, 32'd2);
    check("t3_no_dmem_load", 32'(saw), 32'd0);
`else
    check("t3_dmem_load", 32'(saw), 32'd1);
`endif
    wait_empty();

    // 4: partial hit waits for the buffer to empty, then reads Dmem
    base = retired.size();
    stall_until = cyc + 8;
    do_store(32'h3000, 32'h0000_00AA, 4'b0001, slat);
    do_load(32'h3000, d, llat, saw, rc, gap);
    check("t4_data", d, 32'h5566_77AA);
    check("t4_dmem_load", 32'(saw), 32'd1);
    check("t4_store_retired_first", rc - base, 32'd1);
    check("t4_resp_gap", gap, 32'd1);
    wait_empty();

    // 5: non-overlapping load bypasses a buffered store
    base = retired.size();
    do_store(32'h4000, 32'h0102_0304, 4'hF, slat);
    do_load(32'h5000, d, llat, saw, rc, gap);
    check("t5_data", d, 32'hCAFE_F00D);
    check("t5_dmem_load", 32'(saw), 32'd1);
    check("t5_bypass", rc - base, 32'd0);
    check("t5_resp_gap", gap, 32'd1);
    wait_empty();
    check("t5_store_landed", rd(32'h4000), 32'h0102_0304);

    // 6: reset mid-drain abandons buffered stores
    base = retired.size();
    stall_until = 32'hFFFF_FFFF;
    for (int unsigned i = 0; i < 3; i++) do_store(32'h6000 + 32'(i * 4), 32'hB0 + i, 4'hF, slat);
    tick();
    check("t6_draining", 32'(bus.dmemStoreValid), 32'd1);
    reset = 1'b0;
    tick();
    check_idle_outputs("t6");
    reset = 1'b1;
    stall_until = 0;
    repeat (10) tick();
    check("t6_no_retire", retired.size() - base, 32'd0);
    check("t6_empty_after", 32'(bus.empty), 32'd1);
    for (int unsigned i = 0; i < 3; i++) begin
      a = 32'h6000 + 32'(i * 4);
      check("t6_dmem_untouched", rd(a), init_word(a));
      refm[a >> 2] = rd(a);
    end

    // random mix over a small address window
    for (int k = 0; k < 80; k++) begin
      stall_until = cyc + $urandom_range(0, 3);
      a = 32'h100 + 32'($urandom_range(0, 7) * 4);
      if ($urandom_range(0, 2) != 0) begin
        be = 4'($urandom_range(1, 15));
        sd = $urandom;
        do_store(a, sd, be, slat);
      end else begin
        do_load(a, d, llat, saw, rc, gap);
        check("rnd_load", d, ref_rd(a));
      end
    end
    stall_until = 0;
    wait_empty();
    for (int unsigned i = 0; i < 8; i++) begin
      a = 32'h100 + 32'(i * 4);
      check("rnd_final_mem", rd(a), ref_rd(a));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
